// File: rtl/vnu_ib_ram_refresh_ctrl.sv
// Iteration-refresh sequencer for the row VNU IB-RAMs.
// Streams one iteration's F0, F1 and DN lookup pages out of the IB-ROMs
// and replays each read as a one-hot RAM write once the ROM data is valid.
module vnu_ib_ram_refresh_ctrl #(
  parameter int VN_PAGE_ADDR_BW = 6,
  parameter int DN_PAGE_ADDR_BW = 6,
  parameter int VN_PAGE_NUM     = 64,
  parameter int DN_PAGE_NUM     = 64,
  parameter int VN_ROM_ADDR_BW  = 11,
  parameter int DN_ROM_ADDR_BW  = 11,
  parameter int ITER_NUM        = 10,
  parameter int ITER_ADDR_BW    = 4,
  parameter int ROM_RD_LATENCY  = 2
) (
  input  logic                       read_clk,
  input  logic                       rstn,
  input  logic                       iter_update_req,
  input  logic [ITER_ADDR_BW-1:0]    iter_target,
  output logic                       busy,
  output logic                       decode_hold,
  output logic                       update_done,
  output logic                       req_err,
  output logic                       vn_rom_en,
  output logic [VN_ROM_ADDR_BW-1:0]  vn_rom_addr,
  output logic                       dn_rom_en,
  output logic [DN_ROM_ADDR_BW-1:0]  dn_rom_addr,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_0,
  output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_1,
  output logic [DN_PAGE_ADDR_BW:0]   page_addr_ram_2,
  output logic [2:0]                 ib_ram_we
);

  localparam int VP_W  = VN_PAGE_ADDR_BW + 1;
  localparam int DP_W  = DN_PAGE_ADDR_BW + 1;
  localparam int CNT_W = (VP_W > DP_W) ? VP_W : DP_W;
  // Registers between the issue and the write-enable register; the write
  // register itself is the final stage of the ROM latency.
  localparam int PD    = (ROM_RD_LATENCY > 1) ? ROM_RD_LATENCY - 1 : 1;

  localparam logic [CNT_W-1:0] VN_LAST    = CNT_W'(VN_PAGE_NUM - 1);
  localparam logic [CNT_W-1:0] DN_LAST    = CNT_W'(DN_PAGE_NUM - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(ROM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_F0 = 3'd1,
    LOAD_F1 = 3'd2,
    LOAD_DN = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t                   state;
  logic [ITER_ADDR_BW-1:0]  iter_q;
  logic [CNT_W-1:0]         page;
  logic [2:0]               drain_cnt;

  logic                     cur_vld;
  logic [1:0]               cur_ram;
  logic                     tap_vld;
  logic [1:0]               tap_ram;
  logic [CNT_W-1:0]         tap_page;

  // First F0 address of an iteration: iter * 2 * VN_PAGE_NUM, wrapped to the port.
  function automatic logic [VN_ROM_ADDR_BW-1:0] vn_base(input logic [ITER_ADDR_BW-1:0] it);
    return VN_ROM_ADDR_BW'(32'(it) * 32'(2 * VN_PAGE_NUM));
  endfunction

  // First DN address of an iteration: iter * DN_PAGE_NUM, wrapped to the port.
  function automatic logic [DN_ROM_ADDR_BW-1:0] dn_base(input logic [ITER_ADDR_BW-1:0] it);
    return DN_ROM_ADDR_BW'(32'(it) * 32'(DN_PAGE_NUM));
  endfunction

  assign decode_hold = busy;

  // Sequencer: accepts/rejects requests and issues back-to-back ROM reads.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      state       <= IDLE;
      iter_q      <= '0;
      page        <= '0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      req_err     <= 1'b0;
      vn_rom_en   <= 1'b0;
      vn_rom_addr <= '0;
      dn_rom_en   <= 1'b0;
      dn_rom_addr <= '0;
    end else begin
      update_done <= 1'b0;
      req_err     <= 1'b0;
      // Any request during a refresh is dropped and flagged.
      if (state != IDLE && iter_update_req) begin
        req_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (iter_update_req) begin
            if (32'(iter_target) < 32'(ITER_NUM)) begin
              state       <= LOAD_F0;
              iter_q      <= iter_target;
              page        <= '0;
              busy        <= 1'b1;
              vn_rom_en   <= 1'b1;
              vn_rom_addr <= vn_base(iter_target);
            end else begin
              req_err <= 1'b1;
            end
          end
        end
        LOAD_F0: begin
          // F1 pages directly follow F0 in the ROM, so the address just keeps counting.
          vn_rom_addr <= vn_rom_addr + 1'b1;
          if (page == VN_LAST) begin
            state <= LOAD_F1;
            page  <= '0;
          end else begin
            page <= page + 1'b1;
          end
        end
        LOAD_F1: begin
          if (page == VN_LAST) begin
            state       <= LOAD_DN;
            page        <= '0;
            vn_rom_en   <= 1'b0;
            dn_rom_en   <= 1'b1;
            dn_rom_addr <= dn_base(iter_q);
          end else begin
            page        <= page + 1'b1;
            vn_rom_addr <= vn_rom_addr + 1'b1;
          end
        end
        LOAD_DN: begin
          if (page == DN_LAST) begin
            state     <= DRAIN;
            page      <= '0;
            drain_cnt <= '0;
            dn_rom_en <= 1'b0;
          end else begin
            page        <= page + 1'b1;
            dn_rom_addr <= dn_rom_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            update_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decode the read being issued this cycle into a target RAM index.
  always_comb begin
    cur_vld = 1'b0;
    cur_ram = 2'd0;
    case (state)
      LOAD_F0: begin cur_vld = 1'b1; cur_ram = 2'd0; end
      LOAD_F1: begin cur_vld = 1'b1; cur_ram = 2'd1; end
      LOAD_DN: begin cur_vld = 1'b1; cur_ram = 2'd2; end
      default: begin cur_vld = 1'b0; cur_ram = 2'd0; end
    endcase
  end

  generate
    if (ROM_RD_LATENCY > 1) begin : g_pipe
      logic             vld_p  [PD];
      logic [1:0]       ram_p  [PD];
      logic [CNT_W-1:0] page_p [PD];

      // Delay each issued (RAM, page) until its ROM data is on the bus.
      always_ff @(posedge read_clk) begin
        if (!rstn) begin
          for (int k = 0; k < PD; k++) begin
            vld_p[k]  <= 1'b0;
            ram_p[k]  <= '0;
            page_p[k] <= '0;
          end
        end else begin
          vld_p[0]  <= cur_vld;
          ram_p[0]  <= cur_ram;
          page_p[0] <= page;
          for (int k = 1; k < PD; k++) begin
            vld_p[k]  <= vld_p[k-1];
            ram_p[k]  <= ram_p[k-1];
            page_p[k] <= page_p[k-1];
          end
        end
      end

      assign tap_vld  = vld_p[PD-1];
      assign tap_ram  = ram_p[PD-1];
      assign tap_page = page_p[PD-1];
    end else begin : g_nopipe
      assign tap_vld  = cur_vld;
      assign tap_ram  = cur_ram;
      assign tap_page = page;
    end
  endgenerate

  // Write stage: one-hot enable plus the page for the addressed RAM; others hold.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      ib_ram_we       <= 3'b000;
      page_addr_ram_0 <= '0;
      page_addr_ram_1 <= '0;
      page_addr_ram_2 <= '0;
    end else begin
      ib_ram_we <= 3'b000;
      if (tap_vld) begin
        case (tap_ram)
          2'd0: begin
            ib_ram_we       <= 3'b001;
            page_addr_ram_0 <= VP_W'(tap_page);
          end
          2'd1: begin
            ib_ram_we       <= 3'b010;
            page_addr_ram_1 <= VP_W'(tap_page);
          end
          2'd2: begin
            ib_ram_we       <= 3'b100;
            page_addr_ram_2 <= DP_W'(tap_page);
          end
          default: begin
            ib_ram_we <= 3'b000;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vnu_ib_ram_refresh_ctrl.md
Name: vnu_ib_ram_refresh_ctrl

Overview:
Iteration-refresh sequencer for the row VNU array's IB-RAMs. For each decoding iteration it loads that iteration's IB lookup pages into three RAMs:
- partial-VNU F0 RAM (RAM 0)
- partial-VNU F1 RAM (RAM 1)
- decision-node RAM (RAM 2)

It reads the IB-ROMs and drives page_addr_ram_0/1/2 and ib_ram_we[2:0], time-aligned with the ROM read data. It holds off decoding while a refresh is in progress.

Parameters:
- VN_PAGE_ADDR_BW, 6, VN page address width (the page port is VN_PAGE_ADDR_BW+1 bits wide)
- DN_PAGE_ADDR_BW, 6, DN page address width (the page port is DN_PAGE_ADDR_BW+1 bits wide)
- VN_PAGE_NUM, 64, pages per VN function (F0 or F1) per iteration; must be ≤ 2^(VN_PAGE_ADDR_BW+1)
- DN_PAGE_NUM, 64, DN pages per iteration; must be ≤ 2^(DN_PAGE_ADDR_BW+1)
- VN_ROM_ADDR_BW, 11, VN IB-ROM address width
- DN_ROM_ADDR_BW, 11, DN IB-ROM address width
- ITER_NUM, 10, number of valid iterations
- ITER_ADDR_BW, 4, width of iter_target
- ROM_RD_LATENCY, 2, cycles from rom_en/addr to valid ROM data (range 1..4)

Ports:
- read_clk  in  1  single clock for the block
- rstn  in  1  synchronous, active-low reset
- iter_update_req  in  1  one-cycle request to start a refresh
- iter_target  in  ITER_ADDR_BW  iteration index; sampled with the request
- busy  out  1  refresh in progress
- decode_hold  out  1  equal to busy; stalls the VNU datapath
- update_done  out  1  one-cycle pulse when a refresh completes
- req_err  out  1  one-cycle pulse when a request is rejected
- vn_rom_en  out  1  VN IB-ROM read enable
- vn_rom_addr  out  VN_ROM_ADDR_BW  VN IB-ROM read address
- dn_rom_en  out  1  DN IB-ROM read enable
- dn_rom_addr  out  DN_ROM_ADDR_BW  DN IB-ROM read address
- page_addr_ram_0  out  VN_PAGE_ADDR_BW+1  F0 RAM write page
- page_addr_ram_1  out  VN_PAGE_ADDR_BW+1  F1 RAM write page
- page_addr_ram_2  out  DN_PAGE_ADDR_BW+1  DN RAM write page
- ib_ram_we  out  3  per-RAM write enables; bit0 = F0, bit1 = F1, bit2 = DN

Behaviour:
- Clocking and reset: one clock, read_clk. Reset is synchronous, active-low on rstn. All outputs are registered.
- Reset values:
  - state = IDLE
  - all enables and pulses = 0
  - all addresses = 0
  - the write-alignment pipeline is cleared
- States: IDLE, LOAD_F0, LOAD_F1, LOAD_DN, DRAIN.
- IDLE, request acceptance:
  - iter_update_req=1 with iter_target<ITER_NUM: latch iter_target, clear the page counter, go to LOAD_F0.
  - iter_update_req=1 with iter_target≥ITER_NUM: pulse req_err next cycle, stay in IDLE.
- Request while busy: ignored, with a req_err pulse on the next cycle. The refresh in progress is unaffected.
- LOAD_F0 and LOAD_F1: one VN ROM read per cycle, back-to-back, for page p=0..VN_PAGE_NUM-1.
  - vn_rom_en=1.
  - vn_rom_addr = iter*2*VN_PAGE_NUM + f*VN_PAGE_NUM + p, where f=0 in LOAD_F0 and f=1 in LOAD_F1; truncated to the port width.
  - After the last page, move to the next state with no bubble cycle.
- LOAD_DN: dn_rom_en=1, dn_rom_addr = iter*DN_PAGE_NUM + p, for p=0..DN_PAGE_NUM-1. Then go to DRAIN.
- Write alignment: each issued read (RAM index, page) passes through a ROM_RD_LATENCY-deep shift register.
  - At exit, assert the one-hot ib_ram_we bit and drive the matching page_addr_ram_x = p, zero-extended.
  - ib_ram_we is never more than one-hot.
  - Each page_addr_ram_x holds its last written value between writes.
- DRAIN: lasts ROM_RD_LATENCY cycles, until the shift register is empty. Then return to IDLE with update_done=1 for that one cycle.
- busy and decode_hold:
  - 1 from the cycle after acceptance through the last DRAIN cycle.
  - 0 in the update_done cycle.
  - A request arriving in the update_done cycle is accepted normally.
- Timing, with acceptance at edge 0 and defaults (L=2):
  - ROM issues occur in cycles 1..192: F0 in 1..64, F1 in 65..128, DN in 129..192.
  - Writes occur in cycles 3..194.
  - update_done occurs in cycle 195.
- Reset mid-operation: on the next edge every output returns to its reset value and no further writes occur. The RAM contents are treated as invalid; a new request is required.

Test Plan:
- Reset and idle: hold rstn=0 for 3 cycles, then release with no request.
  → All outputs are 0; busy stays 0 for 20 cycles.
- Normal refresh, iter_target=3, defaults.
  - Cycle 1: vn_rom_addr=384.
  - Cycle 3: ib_ram_we=3'b001, page_addr_ram_0=0.
  - Cycle 65: vn_rom_addr=448.
  - Cycle 67: ib_ram_we=3'b010, page_addr_ram_1=0.
  - Cycle 129: dn_rom_addr=192.
  - Cycle 194: ib_ram_we=3'b100, page_addr_ram_2=63.
  - Cycle 195: update_done=1, busy=0.
  - Exactly 192 write cycles in total.
- Invalid target: request with iter_target=10.
  → req_err=1 for one cycle; busy=0; no ROM or RAM activity.
- Request while busy: second request at cycle 50.
  → req_err pulses at cycle 51; the sequence and addresses are identical to the normal refresh case.
- Reset mid-operation: rstn=0 at cycle 100.
  → On the next edge, ib_ram_we=0, busy=0, vn_rom_en=0. A request for iter 0 after reset completes with update_done 195 cycles later.
- Back-to-back: request iter 9 asserted in the update_done cycle of the previous refresh.
  → Accepted; the first vn_rom_addr is 1152; no req_err.
